// File: rtl/byte_pair_sequencer.sv
// byte_pair_sequencer: pairs UART bytes (low first, then high) into 16-bit words for the LED driver.
// Latency: word_valid rises 1 cycle after the high-byte rx_valid; errored pairs carry ERROR_PATTERN.
// Backpressure: none upstream; an unacked word is replaced and overrun pulses. SEQ_ERR_COUNT_EN builds err_count.
module byte_pair_sequencer #(
   parameter logic [15:0] ERROR_PATTERN  = 16'hCCCC,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
   parameter int          CNT_W          = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_perror,
   input  logic             rx_ferror,
   input  logic             word_ack,
   output logic [15:0]      word_out,
   output logic             word_valid,
   output logic             overrun,
   output logic             timeout,
   output logic [CNT_W-1:0] err_count
);

   // Pairing state: waiting for the low byte, or holding it while the high byte arrives.
   localparam logic [0:0] WAIT_LO = 1'b0;
   localparam logic [0:0] WAIT_HI = 1'b1;

   // Counter value on the last idle cycle allowed before the low byte is dropped.
   localparam logic [15:0] TO_LIMIT = TIMEOUT_CYCLES - 16'd1;
   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 16'd0);

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [7:0]  lo_byte;
   logic        err_flag;
   logic [15:0] to_cnt;

   logic        rx_err;
   logic        lo_take;
   logic        pair_done;
   logic        pair_err;
   logic        to_fire;
   logic [15:0] pair_word;

   // Either receiver error strobe taints the pair currently being assembled.
   assign rx_err    = rx_perror | rx_ferror;
   assign lo_take   = (state == WAIT_LO) && rx_valid;
   assign pair_done = (state == WAIT_HI) && rx_valid;

   // A coincident strobe on the high byte still counts for this pair.
   assign pair_err  = err_flag | rx_err;
   assign pair_word = pair_err ? ERROR_PATTERN : {rx_data, lo_byte};

   // rx_valid on the limit cycle wins: only an idle cycle can fire the timeout.
   assign to_fire   = TO_EN && (state == WAIT_HI) && !rx_valid && (to_cnt == TO_LIMIT);

   // Next-state: a byte moves between halves, a timeout forces resync to the low half.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LO: begin
            if (rx_valid) begin
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (rx_valid || to_fire) begin
               state_nxt = WAIT_LO;
            end
         end
         default: begin
            state_nxt = WAIT_LO;
         end
      endcase
   end

   // State register; reset discards any half-received pair.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= WAIT_LO;
      end else begin
         state <= state_nxt;
      end
   end

   // Low-byte holding register, dropped on timeout so a stale byte never leaks out.
   always_ff @(posedge clk) begin
      if (reset) begin
         lo_byte <= 8'h00;
      end else if (lo_take) begin
         lo_byte <= rx_data;
      end else if (to_fire) begin
         lo_byte <= 8'h00;
      end
   end

   // Sticky error flag: pair end or discard starts the next pair clean, otherwise any strobe sets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_flag <= 1'b0;
      end else if (pair_done || to_fire) begin
         err_flag <= 1'b0;
      end else if (rx_err) begin
         err_flag <= 1'b1;
      end
   end

   // Inter-byte idle counter; holds at all-ones when the timeout is disabled so it cannot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= 16'd0;
      end else if (lo_take || to_fire) begin
         to_cnt <= 16'd0;
      end else if ((state == WAIT_HI) && !rx_valid && (to_cnt != 16'hFFFF)) begin
         to_cnt <= to_cnt + 16'd1;
      end
   end

   // Output word and handshake: a completed pair always loads, an ack without a new pair retires the word.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_out   <= 16'h0000;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (pair_done) begin
            word_out   <= pair_word;
            word_valid <= 1'b1;
            // Same-cycle ack means the old word was consumed, so nothing was lost.
            overrun    <= word_valid && !word_ack;
         end else if (word_valid && word_ack) begin
            word_valid <= 1'b0;
         end
      end
   end

   // Timeout pulse, one cycle per discarded low byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout <= 1'b0;
      end else begin
         timeout <= to_fire;
      end
   end

`ifdef SEQ_ERR_COUNT_EN
   logic [CNT_W-1:0] err_cnt_q;

   // Errored pairs actually delivered, saturating rather than wrapping; timeouts are not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (pair_done && pair_err && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_byte_pair_sequencer.sv
// Testbench for byte_pair_sequencer: directed scenarios plus randomized traffic against a pair-level model.
// Runs with TIMEOUT_CYCLES=16 and CNT_W=2; err_count expectations follow SEQ_ERR_COUNT_EN.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_byte_pair_sequencer;

   localparam logic [15:0] ERR_PAT = 16'hCCCC;
   localparam int          TMO     = 16;
   localparam int          CW      = 2;
   localparam int          CMAX    = (1 << CW) - 1;
`ifdef SEQ_ERR_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_perror = 1'b0;
   logic          rx_ferror = 1'b0;
   logic          word_ack = 1'b0;
   logic [15:0]   word_out;
   logic          word_valid;
   logic          overrun;
   logic          timeout;
   logic [CW-1:0] err_count;

   int n_vec = 0;
   int n_err = 0;

   // Pair-level model: what has been received, and what the LED side should see.
   bit          m_have_lo;
   logic [7:0]  m_lo;
   bit          m_bad;
   int          m_gap;
   bit          m_wv;
   logic [15:0] m_word;
   bit          m_ovr;
   bit          m_to;
   int          m_cnt;

   always #5 clk = ~clk;

   byte_pair_sequencer #(
      .ERROR_PATTERN (ERR_PAT),
      .TIMEOUT_CYCLES(16'(TMO)),
      .CNT_W         (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_perror (rx_perror),
      .rx_ferror (rx_ferror),
      .word_ack  (word_ack),
      .word_out  (word_out),
      .word_valid(word_valid),
      .overrun   (overrun),
      .timeout   (timeout),
      .err_count (err_count)
   );

   task automatic model_step(input logic rv, input logic [7:0] rd, input logic pe,
                             input logic fe, input logic ack, input logic rst);
      bit bad;
      bad   = pe | fe;
      m_ovr = 1'b0;
      m_to  = 1'b0;
      if (rst) begin
         m_have_lo = 0; m_lo = 8'h00; m_bad = 0; m_gap = 0;
         m_wv = 0; m_word = 16'h0000; m_cnt = 0;
      end else if (m_have_lo && rv) begin
         m_ovr  = m_wv && !ack;
         m_wv   = 1'b1;
         if (m_bad || bad) begin
            m_word = ERR_PAT;
            if (CNT_ON && m_cnt < CMAX) m_cnt = m_cnt + 1;
         end else begin
            m_word = {rd, m_lo};
         end
         m_have_lo = 0;
         m_bad     = 0;
      end else begin
         if (m_wv && ack) m_wv = 1'b0;
         if (rv) begin
            m_have_lo = 1; m_lo = rd; m_gap = 0;
            if (bad) m_bad = 1;
         end else if (m_have_lo) begin
            m_gap = m_gap + 1;
            if (m_gap == TMO) begin
               m_to = 1; m_have_lo = 0; m_bad = 0;
            end else if (bad) begin
               m_bad = 1;
            end
         end else if (bad) begin
            m_bad = 1;
         end
      end
   endtask

   // One clock: apply inputs, advance the model, then settle past the edge.
   task automatic cyc(input logic rv, input logic [7:0] rd, input logic pe,
                      input logic fe, input logic ack, input logic rst);
      reset = rst; rx_valid = rv; rx_data = rd; rx_perror = pe; rx_ferror = fe; word_ack = ack;
      model_step(rv, rd, pe, fe, ack, rst);
      @(posedge clk);
      #1;
      reset = 1'b0; rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0;
   endtask

   task automatic test_reset();
      cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
      n_vec++; if (word_out !== 16'h0000) begin n_err++; $display("FAIL reset_word: got %h expected 0000", word_out); end
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      n_vec++; if (err_count !== '0) begin n_err++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
   endtask

   task automatic test_clean_pair();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL clean_lo_valid: got %b expected 0", word_valid); end
      cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL clean_valid: got %b expected 1", word_valid); end
      n_vec++; if (word_out !== 16'h1234) begin n_err++; $display("FAIL clean_word: got %h expected 1234", word_out); end
      n_vec++; if (overrun !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL clean_pulses: got ovr=%b to=%b expected 0 0", overrun, timeout); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL clean_drop: got %b expected 0", word_valid); end
   endtask

   task automatic test_errored_pair();
      logic [CW-1:0] exp_cnt;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_cnt = CNT_ON ? CW'(1) : CW'(0);
      n_vec++; if (word_out !== 16'hCCCC || word_valid !== 1'b1) begin n_err++; $display("FAIL err_word: got %h/%b expected cccc/1", word_out, word_valid); end
      n_vec++; if (err_count !== exp_cnt) begin n_err++; $display("FAIL err_count1: got %0d expected %0d", err_count, exp_cnt); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_out !== 16'h0201 || word_valid !== 1'b1) begin n_err++; $display("FAIL err_next_clean: got %h/%b expected 0201/1", word_out, word_valid); end
      n_vec++; if (err_count !== exp_cnt) begin n_err++; $display("FAIL err_count_hold: got %0d expected %0d", err_count, exp_cnt); end
   endtask

   task automatic test_timeout();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
         n_vec++; if (timeout !== (i == TMO)) begin n_err++; $display("FAIL timeout_pulse[%0d]: got %b expected %b", i, timeout, (i == TMO)); end
         n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL timeout_novalid[%0d]: got %b expected 0", i, word_valid); end
      end
      cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL timeout_resync_lo: got %b expected 0", word_valid); end
      cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_out !== 16'h3322 || word_valid !== 1'b1) begin n_err++; $display("FAIL timeout_resync_word: got %h/%b expected 3322/1", word_out, word_valid); end
   endtask

   task automatic test_overrun();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (word_out !== 16'h0201 || overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: got %h ovr=%b expected 0201 0", word_out, overrun); end
      cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (word_valid !== 1'b1 || word_out !== 16'h0201) begin n_err++; $display("FAIL ovr_hold: got %h/%b expected 0201/1", word_out, word_valid); end
      cyc(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (word_out !== 16'h0403 || word_valid !== 1'b1 || overrun !== 1'b1) begin n_err++; $display("FAIL ovr_replace: got %h/%b ovr=%b expected 0403/1 1", word_out, word_valid, overrun); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (overrun !== 1'b0 || word_valid !== 1'b1) begin n_err++; $display("FAIL ovr_once: got ovr=%b vld=%b expected 0 1", overrun, word_valid); end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack_clear: got %b expected 0", word_valid); end
   endtask

   task automatic test_back_to_back();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL b2b_stray_ack: got %b expected 0", word_valid); end
      cyc(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_out !== 16'h0807 || word_valid !== 1'b1 || overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ack_load: got %h/%b ovr=%b expected 0807/1 0", word_out, word_valid, overrun); end
   endtask

   task automatic test_reset_mid_pair();
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
      n_vec++; if (word_out !== 16'h0000 || word_valid !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0 || err_count !== '0) begin
         n_err++; $display("FAIL midreset_outputs: got %h/%b/%b/%b/%0d expected 0000/0/0/0/0", word_out, word_valid, overrun, timeout, err_count);
      end
      cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++; if (word_out !== 16'h2010 || word_valid !== 1'b1) begin n_err++; $display("FAIL midreset_word: got %h/%b expected 2010/1", word_out, word_valid); end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] exp_cnt;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 8'(k), (k % 2) == 1, 1'b0, 1'b1, 1'b0);
         cyc(1'b1, 8'(k + 16), 1'b0, (k % 2) == 0, 1'b1, 1'b0);
         exp_cnt = CNT_ON ? CW'((k < CMAX) ? k : CMAX) : CW'(0);
         n_vec++; if (err_count !== exp_cnt || word_out !== ERR_PAT) begin
            n_err++; $display("FAIL sat_count[%0d]: got %0d/%h expected %0d/%h", k, err_count, word_out, exp_cnt, ERR_PAT);
         end
      end
   endtask

   task automatic test_random();
      logic       rv, pe, fe, ack, rst;
      logic [7:0] rd;
      int         idle;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 3000; n++) begin
         idle = ($urandom_range(0, 29) == 0) ? $urandom_range(10, 20) : 0;
         rv   = (idle == 0) && ($urandom_range(0, 1) == 1);
         rd   = 8'($urandom);
         pe   = rv && ($urandom_range(0, 9) == 0);
         fe   = rv && ($urandom_range(0, 9) == 0);
         ack  = $urandom_range(0, 2) != 0;
         rst  = $urandom_range(0, 249) == 0;
         for (int j = 0; j <= idle; j++) begin
            cyc(rv && (j == idle), rd, pe && (j == idle), fe && (j == idle), ack, rst && (j == idle));
            n_vec++; if (word_valid !== m_wv) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, word_valid, m_wv); end
            n_vec++; if (word_out !== m_word) begin n_err++; $display("FAIL rnd_word@%0d: got %h expected %h", n, word_out, m_word); end
            n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rnd_overrun@%0d: got %b expected %b", n, overrun, m_ovr); end
            n_vec++; if (timeout !== m_to) begin n_err++; $display("FAIL rnd_timeout@%0d: got %b expected %b", n, timeout, m_to); end
            n_vec++; if (err_count !== CW'(m_cnt)) begin n_err++; $display("FAIL rnd_errcnt@%0d: got %0d expected %0d", n, err_count, m_cnt); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_pair();
      test_errored_pair();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_reset_mid_pair();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
